mem_port_arbiter: RTL and testbench

Shares the single data-memory port between the RV32I processor core's load/store path and the VGA pixel fetcher. Each cycle it grants at most one requester and drives the memory's address/data/control lines from the winner. It routes the synchronous read data back one cycle later to whichever port issued the read. VGA has fixed priority to keep scan-out on time; a saturating wait counter bounds how long the processor can be starved.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous data-memory port between the CPU load/store path
// and the VGA pixel fetcher. VGA has priority; a saturating wait counter bounds CPU starvation.
module mem_port_arbiter #(
   parameter int unsigned MAX_CPU_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [1:0]  cpu_window_size,
   input  logic        cpu_zero_extension,
   output logic        cpu_ack,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        vga_req,
   input  logic [31:0] vga_addr,
   output logic        vga_ack,
   output logic        vga_rvalid,
   output logic [31:0] vga_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_window_size,
   output logic        mem_zero_extension,
   input  logic [31:0] mem_rdata,
   output logic        cpu_starved
);

   typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_CPU = 2'd1, TAG_VGA = 2'd2} tag_t;

   localparam logic [7:0] LP_THR = 8'(MAX_CPU_WAIT);

   logic [7:0] r_wait_cnt;
   tag_t       r_tag;
   tag_t       w_tag_nxt;
   logic       w_thr_hit;
   logic       w_override;
   logic       w_cpu_gnt;
   logic       w_vga_gnt;

   // wait_cnt >= LP_THR, written so a zero threshold is not a constant-true compare
   assign w_thr_hit  = ({1'b0, r_wait_cnt} + 9'd1) > {1'b0, LP_THR};
   assign w_override = cpu_req & w_thr_hit;

   always_comb begin
      w_cpu_gnt = 1'b0;
      w_vga_gnt = 1'b0;
      if (w_override)   w_cpu_gnt = 1'b1;
      else if (vga_req) w_vga_gnt = 1'b1;
      else if (cpu_req) w_cpu_gnt = 1'b1;
   end

   assign cpu_ack     = w_cpu_gnt;
   assign vga_ack     = w_vga_gnt;
   assign cpu_starved = w_override & vga_req;

   always_comb begin
      mem_en             = 1'b0;
      mem_we             = 1'b0;
      mem_addr           = 32'd0;
      mem_wdata          = 32'd0;
      mem_window_size    = 2'b00;
      mem_zero_extension = 1'b0;
      if (w_cpu_gnt) begin
         mem_en             = 1'b1;
         mem_we             = cpu_we;
         mem_addr           = cpu_addr;
         mem_wdata          = cpu_wdata;
         mem_window_size    = cpu_window_size;
         mem_zero_extension = cpu_zero_extension;
      end else if (w_vga_gnt) begin
         mem_en          = 1'b1;
         mem_addr        = vga_addr;
         mem_window_size = 2'b10;
      end
   end

   always_comb begin
      w_tag_nxt = TAG_NONE;
      if (w_cpu_gnt && !cpu_we) w_tag_nxt = TAG_CPU;
      else if (w_vga_gnt)       w_tag_nxt = TAG_VGA;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= 8'd0;
         r_tag      <= TAG_NONE;
      end else begin
         r_tag <= w_tag_nxt;
         if (cpu_req && !w_cpu_gnt) begin
            if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
         end else begin
            r_wait_cnt <= 8'd0;
         end
      end
   end

   // Read data is steered by the tag captured when the read was granted
   assign cpu_rvalid = (r_tag == TAG_CPU);
   assign vga_rvalid = (r_tag == TAG_VGA);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
   assign vga_rdata  = vga_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter; two instances (threshold 4 and 0)
// run side by side, each with its own requesters and reference model.
module tb_mem_port_arbiter;

   localparam int THR[2] = '{4, 0};

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_rdata;

   logic        cpu_req[2], cpu_we[2], cpu_ze[2], vga_req[2];
   logic [31:0] cpu_addr[2], cpu_wdata[2], vga_addr[2];
   logic [1:0]  cpu_ws[2];

   logic        cpu_ack[2], cpu_rvalid[2], vga_ack[2], vga_rvalid[2], cpu_starved[2];
   logic [31:0] cpu_rdata[2], vga_rdata[2];
   logic        mem_en[2], mem_we[2], mem_ze[2];
   logic [31:0] mem_addr[2], mem_wdata[2];
   logic [1:0]  mem_ws[2];

   mem_port_arbiter #(.MAX_CPU_WAIT(4)) u0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
      .cpu_window_size(cpu_ws[0]), .cpu_zero_extension(cpu_ze[0]),
      .cpu_ack(cpu_ack[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
      .vga_req(vga_req[0]), .vga_addr(vga_addr[0]),
      .vga_ack(vga_ack[0]), .vga_rvalid(vga_rvalid[0]), .vga_rdata(vga_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_window_size(mem_ws[0]), .mem_zero_extension(mem_ze[0]),
      .mem_rdata(mem_rdata), .cpu_starved(cpu_starved[0]));

   mem_port_arbiter #(.MAX_CPU_WAIT(0)) u1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
      .cpu_window_size(cpu_ws[1]), .cpu_zero_extension(cpu_ze[1]),
      .cpu_ack(cpu_ack[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
      .vga_req(vga_req[1]), .vga_addr(vga_addr[1]),
      .vga_ack(vga_ack[1]), .vga_rvalid(vga_rvalid[1]), .vga_rdata(vga_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_window_size(mem_ws[1]), .mem_zero_extension(mem_ze[1]),
      .mem_rdata(mem_rdata), .cpu_starved(cpu_starved[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          inst;
      bit          is_cpu;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   int nchecks = 0;
   int nfail   = 0;

   // Requester intent, copied onto the DUT pins just after each rising edge
   logic        ic_req[2], ic_we[2], ic_ze[2], iv_req[2], ir_rst;
   logic [31:0] ic_addr[2], ic_wdata[2], iv_addr[2];
   logic [1:0]  ic_ws[2];
   int          wc[2];
   logic [31:0] next_rd, fix_rd;
   bit          use_fix;
   logic        a_cpu[2], a_st[2];

   task automatic chk(input string nm, input int inst, input logic [71:0] act, input logic [71:0] exp);
      nchecks++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s[%0d] got=%0h want=%0h (cycle %0d)", nm, inst, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      logic        e_cv[2], e_vv[2];
      logic [31:0] e_cd[2], e_vd[2];
      exp_t        e;
      for (int i = 0; i < 2; i++) begin
         e_cv[i] = 0; e_vv[i] = 0; e_cd[i] = 0; e_vd[i] = 0;
      end
      while (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         if (e.is_cpu) begin e_cv[e.inst] = 1; e_cd[e.inst] = e.data; end
         else          begin e_vv[e.inst] = 1; e_vd[e.inst] = e.data; end
      end
      for (int i = 0; i < 2; i++) begin
         chk("cpu_rsp", i, {39'd0, cpu_rvalid[i], cpu_rdata[i]}, {39'd0, e_cv[i], e_cd[i]});
         chk("vga_rsp", i, {39'd0, vga_rvalid[i], vga_rdata[i]}, {39'd0, e_vv[i], e_vd[i]});
      end
   end

   // Reference: spec priority rules on the intent, checked just before the sampling edge
   task automatic check_all();
      logic [31:0] nxt;
      logic        creq, vreq, ovr, gc, gv;
      logic [68:0] bus;
      nxt = use_fix ? fix_rd : $urandom;
      for (int i = 0; i < 2; i++) begin
         creq = ic_req[i];
         vreq = iv_req[i];
         ovr  = creq && (wc[i] >= THR[i]);
         gc   = ovr || (creq && !vreq);
         gv   = vreq && !gc;
         if (gc)      bus = {1'b1, ic_we[i], ic_addr[i], ic_wdata[i], ic_ws[i], ic_ze[i]};
         else if (gv) bus = {2'b10, iv_addr[i], 32'd0, 2'b10, 1'b0};
         else         bus = '0;
         chk("acks", i, {70'd0, cpu_ack[i], vga_ack[i]}, {70'd0, gc, gv});
         chk("starved", i, {71'd0, cpu_starved[i]}, {71'd0, ovr && vreq});
         chk("mem_bus", i, {3'd0, mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i], mem_ws[i], mem_ze[i]},
             {3'd0, bus});
         a_cpu[i] = cpu_ack[i];
         a_st[i]  = cpu_starved[i];
         if (!rst_n)            wc[i] = 0;
         else if (creq && !gc)  wc[i] = (wc[i] < 255) ? wc[i] + 1 : 255;
         else                   wc[i] = 0;
         if (rst_n && ((gc && !ic_we[i]) || gv)) sb.push_back('{i, gc, nxt, cyc + 1});
         if (gc) ic_req[i] = 0;
         if (gv) iv_req[i] = 0;
      end
      next_rd = nxt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n && !ir_rst) begin
         sb.delete();
         wc[0] = 0;
         wc[1] = 0;
      end
      rst_n = ir_rst;
      for (int i = 0; i < 2; i++) begin
         cpu_req[i] = ic_req[i]; cpu_we[i] = ic_we[i]; cpu_addr[i] = ic_addr[i];
         cpu_wdata[i] = ic_wdata[i]; cpu_ws[i] = ic_ws[i]; cpu_ze[i] = ic_ze[i];
         vga_req[i] = iv_req[i]; vga_addr[i] = iv_addr[i];
      end
      mem_rdata = next_rd;
      @(negedge clk);
      check_all();
   endtask

   task automatic new_cpu(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] ws, input logic ze);
      ic_req[i] = 1; ic_we[i] = we; ic_addr[i] = a; ic_wdata[i] = d; ic_ws[i] = ws; ic_ze[i] = ze;
   endtask

   task automatic rand_reqs();
      for (int i = 0; i < 2; i++) begin
         if (!ic_req[i] && $urandom_range(0, 2) != 0)
            new_cpu(i, 1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom));
         if (!iv_req[i] && $urandom_range(0, 1) != 0) begin
            iv_req[i] = 1;
            iv_addr[i] = $urandom;
         end
      end
   endtask

   initial begin
      int first_ack[2];
      logic st_at[2];
      rst_n = 1; ir_rst = 0; use_fix = 0; fix_rd = 0; next_rd = 0; mem_rdata = 0;
      for (int i = 0; i < 2; i++) begin
         ic_req[i] = 0; ic_we[i] = 0; ic_addr[i] = 0; ic_wdata[i] = 0; ic_ws[i] = 0; ic_ze[i] = 0;
         iv_req[i] = 0; iv_addr[i] = 0; wc[i] = 0;
         cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 0; cpu_wdata[i] = 0; cpu_ws[i] = 0; cpu_ze[i] = 0;
         vga_req[i] = 0; vga_addr[i] = 0;
      end
      #1 rst_n = 0;
      repeat (3) tick();
      ir_rst = 1;
      tick();

      // Single CPU load returning 0xDEADBEEF
      use_fix = 1; fix_rd = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) new_cpu(i, 0, 32'h100, 0, 2'b10, 0);
      tick();
      use_fix = 0;
      tick();

      // Held contention: count cycles until the CPU is acknowledged
      for (int i = 0; i < 2; i++) begin first_ack[i] = 0; st_at[i] = 0; end
      new_cpu(0, 0, 32'h40, 0, 2'b10, 0);
      for (int k = 1; k <= 8; k++) begin
         for (int i = 0; i < 2; i++) begin iv_req[i] = 1; iv_addr[i] = 32'h8000 + 4 * k; end
         new_cpu(1, 0, 32'h80 + 4 * k, 0, 2'b10, 0);
         tick();
         for (int i = 0; i < 2; i++)
            if (a_cpu[i] && first_ack[i] == 0) begin first_ack[i] = k; st_at[i] = a_st[i]; end
      end
      for (int i = 0; i < 2; i++) begin
         chk("starve_bound", i, 72'(first_ack[i]), 72'(THR[i] + 1));
         chk("starve_pulse", i, {71'd0, st_at[i]}, 72'd1);
      end
      for (int i = 0; i < 2; i++) begin ic_req[i] = 0; iv_req[i] = 0; end
      tick();

      // VGA read then CPU read back to back
      for (int i = 0; i < 2; i++) begin iv_req[i] = 1; iv_addr[i] = 32'h3000; end
      tick();
      for (int i = 0; i < 2; i++) new_cpu(i, 0, 32'h3004, 0, 2'b10, 1);
      tick();
      tick();

      // CPU store passes through and returns nothing
      for (int i = 0; i < 2; i++) new_cpu(i, 1, 32'h2004, 32'hA5A5A5A5, 2'b01, 0);
      tick();
      tick();

      // Reset while a VGA read is in flight
      for (int i = 0; i < 2; i++) begin iv_req[i] = 1; iv_addr[i] = 32'h5000; end
      tick();
      ir_rst = 0;
      tick();
      for (int i = 0; i < 2; i++) chk("rst_drop", i, {71'd0, vga_rvalid[i]}, 72'd0);
      ir_rst = 1;
      tick();
      for (int i = 0; i < 2; i++) chk("rst_after", i, {71'd0, vga_rvalid[i]}, 72'd0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rand_reqs();
         if ($urandom_range(0, 499) == 0) ir_rst = 0;
         else ir_rst = 1;
         tick();
      end
      ir_rst = 1;
      for (int i = 0; i < 2; i++) begin ic_req[i] = 0; iv_req[i] = 0; end
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule
